// File: rtl/light_pkg.sv
// Shared definitions for the lamp mode controller: mode encodings and the
// mode-to-indicator-LED mapping.
package light_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } light_mode_t;

  localparam logic [3:0] LED_OFF  = 4'b0001;
  localparam logic [3:0] LED_LOW  = 4'b0010;
  localparam logic [3:0] LED_MID  = 4'b0100;
  localparam logic [3:0] LED_HIGH = 4'b1000;

  function automatic logic [3:0] mode_to_led(input light_mode_t mode);
    logic [3:0] led;
    case (mode)
      MODE_OFF:  led = LED_OFF;
      MODE_LOW:  led = LED_LOW;
      MODE_MID:  led = LED_MID;
      default:   led = LED_HIGH;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/light_pwm.sv
// Free-running PWM generator. The duty is shadowed at counter 0 so a duty
// change only ever takes effect on a whole-period boundary.
module light_pwm #(
  parameter int PERIOD = 100,
  localparam int CW = (PERIOD <= 2) ? 1 : $clog2(PERIOD),
  localparam int DW = $clog2(PERIOD + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [DW-1:0] duty_i,
  output logic          pwm_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_q, duty_eff;
  logic [DW-1:0] cnt_ext;
  logic          pwm_q, pwm_d;

  // At counter 0 the new duty is already used for the compare, so the
  // first cycle of a period belongs to the newly loaded duty.
  always_comb begin
    duty_eff = (cnt_q == '0) ? duty_i : duty_q;
    cnt_ext  = DW'(cnt_q);
    cnt_d    = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    pwm_d    = (cnt_ext < duty_eff);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_eff;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/light_mode_controller.sv
// Lamp brightness mode sequencer (OFF->LOW->MID->HIGH->OFF) driving a PWM lamp.
// Define LIGHT_AUTO_OFF_EN to build the idle auto-off timer.
//
// state     | meaning
// MODE_OFF  | lamp dark, idle timer held at 0
// MODE_LOW  | lamp at DUTY_LOW
// MODE_MID  | lamp at DUTY_MID
// MODE_HIGH | lamp at DUTY_HIGH
module light_mode_controller
  import light_pkg::*;
#(
  parameter int PWM_PERIOD      = 100,
  parameter int DUTY_LOW        = 25,
  parameter int DUTY_MID        = 50,
  parameter int DUTY_HIGH       = 100,
  parameter int AUTO_OFF_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_next,
  input  logic       i_btn_off,
  output logic       o_light,
  output logic [1:0] o_mode,
  output logic [3:0] o_mode_led,
  output logic       o_timeout
);

  localparam int DW = $clog2(PWM_PERIOD + 1);

  light_mode_t   mode_q, mode_d;
  logic [DW-1:0] duty_target;
  logic          timeout_w;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) mode_q <= MODE_OFF;
    else         mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (i_btn_off)       mode_d = MODE_OFF;
    else if (i_btn_next) mode_d = light_mode_t'(mode_q + 2'd1);
    else if (timeout_w)  mode_d = MODE_OFF;
  end

  always_comb begin
    o_mode     = mode_q;
    o_mode_led = mode_to_led(mode_q);
    case (mode_q)
      MODE_OFF:  duty_target = '0;
      MODE_LOW:  duty_target = DW'(DUTY_LOW);
      MODE_MID:  duty_target = DW'(DUTY_MID);
      default:   duty_target = DW'(DUTY_HIGH);
    endcase
  end

`ifdef LIGHT_AUTO_OFF_EN
  localparam int TW = (AUTO_OFF_CYCLES <= 2) ? 1 : $clog2(AUTO_OFF_CYCLES);

  logic [TW-1:0] idle_q, idle_d;
  logic          idle_tc;

  // Buttons beat the terminal count: they clear the timer and suppress the pulse.
  always_comb begin
    idle_tc   = (idle_q == TW'(AUTO_OFF_CYCLES - 1));
    timeout_w = idle_tc && (mode_q != MODE_OFF) && !i_btn_next && !i_btn_off;
    if (i_btn_next || i_btn_off || (mode_q == MODE_OFF) || idle_tc) idle_d = '0;
    else                                                             idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`else
  logic unused_auto_off;
  assign unused_auto_off = ^AUTO_OFF_CYCLES;
  assign timeout_w       = 1'b0;
`endif

  assign o_timeout = timeout_w;

  light_pwm #(
    .PERIOD(PWM_PERIOD)
  ) u_pwm (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .duty_i  (duty_target),
    .pwm_o   (o_light)
  );

endmodule

// File: tb/tb_light_mode_controller.sv
// Scoreboard bench for light_mode_controller (default parameters).
module tb_light_mode_controller;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_btn_next = 1'b0;
  logic       i_btn_off = 1'b0;
  logic       o_light;
  logic [1:0] o_mode;
  logic [3:0] o_mode_led;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;
  int tb_cnt;
  logic [1:0] model_mode = 2'd0;
  logic [1:0] exp_mode_q[$];
  int         exp_hi_q[$];

  light_mode_controller dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_btn_next (i_btn_next),
    .i_btn_off  (i_btn_off),
    .o_light    (o_light),
    .o_mode     (o_mode),
    .o_mode_led (o_mode_led),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Reference PWM phase: after each edge tb_cnt equals the DUT counter value.
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) tb_cnt <= 0;
    else         tb_cnt <= (tb_cnt == 99) ? 0 : tb_cnt + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic press(input logic nxt, input logic off, output logic [1:0] seen, output logic [3:0] seen_led);
    model_mode = off ? 2'd0 : (nxt ? model_mode + 2'd1 : model_mode);
    exp_mode_q.push_back(model_mode);
    i_btn_next = nxt;
    i_btn_off  = off;
    tick();
    i_btn_next = 1'b0;
    i_btn_off  = 1'b0;
    seen       = o_mode;
    seen_led   = o_mode_led;
  endtask

  task automatic wait_boundary();
    int n = 0;
    tick();
    while (tb_cnt != 1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (tb_cnt != 1) begin
      errors++;
      $display("FAIL boundary_wait: phase %0d required 1 within 200 cycles", tb_cnt);
    end
  endtask

  // Counts high cycles over one full period; optionally pulses buttons at index pulse_at.
  task automatic measure_period(input int pulse_at, input logic nxt, input logic off,
                                output int hi, output logic [1:0] mode_after);
    hi = 0;
    mode_after = o_mode;
    for (int i = 0; i < 100; i++) begin
      if (i == pulse_at + 1) mode_after = o_mode;
      if (o_light === 1'b1) hi++;
      i_btn_next = (i == pulse_at) && nxt;
      i_btn_off  = (i == pulse_at) && off;
      tick();
    end
    i_btn_next = 1'b0;
    i_btn_off  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (o_light !== 1'b0 || o_mode !== 2'd0 || o_mode_led !== 4'b0001 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got light=%b mode=%0d led=%b to=%b required 0 0 0001 0",
               o_light, o_mode, o_mode_led, o_timeout);
    end
    tick();
    i_reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if (o_light !== 1'b0 || o_mode !== 2'd0 || o_mode_led !== 4'b0001 || o_timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d light=%b mode=%0d led=%b to=%b", c,
                 o_light, o_mode, o_mode_led, o_timeout);
      end
    end
  endtask

  task automatic test_next_sequence();
    logic [1:0] seen, exp;
    logic [3:0] seen_led;
    for (int p = 0; p < 5; p++) begin
      press(1'b1, 1'b0, seen, seen_led);
      exp = exp_mode_q.pop_front();
      checks++;
      if (seen !== exp || seen_led !== (4'b0001 << exp)) begin
        errors++;
        $display("FAIL next_step%0d: got mode=%0d led=%b required mode=%0d led=%b",
                 p, seen, seen_led, exp, 4'b0001 << exp);
      end
      for (int g = 0; g < 9; g++) tick();
    end
  endtask

  task automatic test_pwm_duty();
    int duties[3] = '{25, 50, 100};
    int hi, exp_hi;
    logic [1:0] seen, exp, ma;
    logic [3:0] seen_led;
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl > 0) begin
        press(1'b1, 1'b0, seen, seen_led);
        exp = exp_mode_q.pop_front();
        checks++;
        if (seen !== exp) begin
          errors++;
          $display("FAIL duty_mode_step: got %0d required %0d", seen, exp);
        end
      end
      wait_boundary();
      wait_boundary();
      for (int p = 0; p < 3; p++) begin
        exp_hi_q.push_back(duties[lvl]);
        measure_period(-1, 1'b0, 1'b0, hi, ma);
        exp_hi = exp_hi_q.pop_front();
        checks++;
        if (hi !== exp_hi) begin
          errors++;
          $display("FAIL duty_level%0d_period%0d: high cycles %0d required %0d", lvl, p, hi, exp_hi);
        end
      end
    end
  endtask

  task automatic test_duty_change();
    int hi, exp_hi;
    logic [1:0] seen, exp, ma;
    logic [3:0] seen_led;
    for (int k = 0; k < 2; k++) begin
      press(1'b1, 1'b0, seen, seen_led);
      exp = exp_mode_q.pop_front();
      checks++;
      if (seen !== exp) begin
        errors++;
        $display("FAIL change_setup%0d: mode %0d required %0d", k, seen, exp);
      end
    end
    wait_boundary();
    wait_boundary();
    exp_hi_q.push_back(25);
    model_mode = model_mode + 2'd1;
    exp_mode_q.push_back(model_mode);
    measure_period(60, 1'b1, 1'b0, hi, ma);
    exp = exp_mode_q.pop_front();
    exp_hi = exp_hi_q.pop_front();
    checks++;
    if (ma !== exp) begin
      errors++;
      $display("FAIL change_mode: mode %0d required %0d", ma, exp);
    end
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL change_current_period: high %0d required %0d", hi, exp_hi);
    end
    exp_hi_q.push_back(50);
    measure_period(-1, 1'b0, 1'b0, hi, ma);
    exp_hi = exp_hi_q.pop_front();
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL change_next_period: high %0d required %0d", hi, exp_hi);
    end
  endtask

  task automatic test_off_priority();
    int hi, exp_hi;
    logic [1:0] seen, exp, ma;
    logic [3:0] seen_led;
    press(1'b1, 1'b0, seen, seen_led);
    exp = exp_mode_q.pop_front();
    checks++;
    if (seen !== exp) begin
      errors++;
      $display("FAIL off_setup: mode %0d required %0d", seen, exp);
    end
    wait_boundary();
    wait_boundary();
    model_mode = 2'd0;
    exp_mode_q.push_back(model_mode);
    exp_hi_q.push_back(100);
    measure_period(30, 1'b1, 1'b1, hi, ma);
    exp = exp_mode_q.pop_front();
    exp_hi = exp_hi_q.pop_front();
    checks++;
    if (ma !== exp) begin
      errors++;
      $display("FAIL off_wins_mode: mode %0d required %0d", ma, exp);
    end
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL off_current_period: high %0d required %0d", hi, exp_hi);
    end
    exp_hi_q.push_back(0);
    measure_period(-1, 1'b0, 1'b0, hi, ma);
    exp_hi = exp_hi_q.pop_front();
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL off_next_period: high %0d required %0d", hi, exp_hi);
    end
  endtask

  task automatic test_auto_off();
    logic [1:0] seen, exp;
    logic [3:0] seen_led;
`ifdef LIGHT_AUTO_OFF_EN
    int n;
    for (int run = 0; run < 2; run++) begin
      press(1'b1, 1'b0, seen, seen_led);
      exp = exp_mode_q.pop_front();
      checks++;
      if (seen !== exp) begin
        errors++;
        $display("FAIL auto_enter%0d: mode %0d required %0d", run, seen, exp);
      end
      if (run == 1) begin
        for (int c = 0; c < 899; c++) tick();
        press(1'b1, 1'b0, seen, seen_led);
        exp = exp_mode_q.pop_front();
        checks++;
        if (seen !== exp) begin
          errors++;
          $display("FAIL auto_restart_mode: mode %0d required %0d", seen, exp);
        end
      end
      n = 0;
      while (o_timeout !== 1'b1 && n < 1200) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 999) begin
        errors++;
        $display("FAIL auto_timeout%0d: pulse after %0d cycles required 999", run, n);
      end
      tick();
      model_mode = 2'd0;
      checks++;
      if (o_mode !== model_mode || o_timeout !== 1'b0) begin
        errors++;
        $display("FAIL auto_after%0d: mode=%0d to=%b required mode=0 to=0", run, o_mode, o_timeout);
      end
    end
`else
    int pulses = 0;
    press(1'b1, 1'b0, seen, seen_led);
    exp = exp_mode_q.pop_front();
    checks++;
    if (seen !== exp) begin
      errors++;
      $display("FAIL noauto_enter: mode %0d required %0d", seen, exp);
    end
    for (int c = 0; c < 1100; c++) begin
      if (o_timeout !== 1'b0) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0 || o_mode !== model_mode) begin
      errors++;
      $display("FAIL noauto_hold: timeout pulses %0d mode %0d required 0 pulses mode %0d",
               pulses, o_mode, model_mode);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] seen, exp;
    logic [3:0] seen_led;
    while (model_mode != 2'd3) begin
      press(1'b1, 1'b0, seen, seen_led);
      exp = exp_mode_q.pop_front();
      checks++;
      if (seen !== exp) begin
        errors++;
        $display("FAIL rmid_setup: mode %0d required %0d", seen, exp);
      end
    end
    wait_boundary();
    wait_boundary();
    for (int c = 0; c < 37; c++) tick();
    checks++;
    if (o_light !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre_light: light %b required 1", o_light);
    end
    #3 i_reset = 1'b1;
    #1;
    checks++;
    if (o_light !== 1'b0 || o_mode !== 2'd0 || o_mode_led !== 4'b0001 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: light=%b mode=%0d led=%b to=%b required 0 0 0001 0",
               o_light, o_mode, o_mode_led, o_timeout);
    end
    model_mode = 2'd0;
    exp_mode_q.delete();
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (o_mode !== 2'd0 || o_light !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release: mode=%0d light=%b required 0 0", o_mode, o_light);
    end
  endtask

  initial begin
    test_reset();
    test_next_sequence();
    test_pwm_duty();
    test_duty_change();
    test_off_priority();
    test_auto_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
